dcache_responder: RTL and testbench

DCACHE_RESPONDER -- requirements
Module: dcache_responder

---
 rtl/riscv_mem_pkg.sv | 44 ++++
 rtl/dcache_line_ram.sv | 44 ++++
 rtl/dcache_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_dcache_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the data-cache responder and its line RAM:
//   - bus widths of the CPU and backing-memory interfaces
//   - address-field geometry helpers (offset / index / tag widths)
//   - dc_state_e : controller state encoding
// No ports; imported by dcache_responder and dcache_line_ram.
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MASK_W     = DATA_W / 8;
    localparam int BYTE_OFF_W = 2;     // addr[1:0] selects a byte, ignored by the cache
    localparam int TAG_MSB    = 27;    // tag stops here; addr[31:28] is not compared

    localparam int DEF_LINES  = 64;
    localparam int DEF_WORDS  = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        FILL_REQ  = 3'd2,
        FILL_WAIT = 3'd3,
        WRITE_REQ = 3'd4,
        RESPOND   = 3'd5
    } dc_state_e;

    // Word-within-line offset width.
    function automatic int off_width(input int words);
        return $clog2(words);
    endfunction

    // Line index width.
    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    // Tag covers everything above the index up to and including TAG_MSB.
    function automatic int tag_width(input int words, input int lines);
        return TAG_MSB + 1 - BYTE_OFF_W - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// -----------------------------------------------------------------------------
// dcache_line_ram
// Simple dual-port synchronous RAM holding all cache line words.
// One byte-masked write port and one read port with a registered output
// (data appears the cycle after rd_addr is presented). Contents not reset.
// Ports:
//   clk      - clock
//   wr_en    - per-byte write enables (MASK_W bits)
//   wr_addr  - write word address
//   wr_data  - write data
//   rd_addr  - read word address
//   rd_data  - registered read data
// -----------------------------------------------------------------------------
module dcache_line_ram
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = DEF_LINES * DEF_WORDS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [MASK_W-1:0] wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // One byte-wide memory per lane keeps each lane a plain single-enable
    // RAM, which maps cleanly onto block RAM byte-write columns.
    for (genvar gi = 0; gi < MASK_W; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] rd_byte_reg;

        always_ff @(posedge clk) begin
            if (wr_en[gi]) begin
                lane_mem[wr_addr] <= wr_data[gi*8 +: 8];
            end
            rd_byte_reg <= lane_mem[rd_addr];
        end

        assign rd_data[gi*8 +: 8] = rd_byte_reg;
    end

endmodule

// File: rtl/dcache_responder.sv
// -----------------------------------------------------------------------------
// dcache_responder
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Loads that hit return data the cycle after the request with no stall;
// misses fill the whole line from backing memory (WORDS beats, ascending)
// and respond from RESPOND. Every store is forwarded to memory; a store hit
// also merges its bytes into the cached line.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   dcache_addr/we/re/din    - CPU request (held frozen by CPU while stall=1)
//   dcache_dout              - load data (valid on load hit in LOOKUP, or RESPOND)
//   stall                    - pipeline freeze
//   mem_req_*                - backing-memory request channel (valid/ready)
//   mem_resp_valid/data      - backing-memory read beats, no backpressure
// -----------------------------------------------------------------------------
module dcache_responder
    import riscv_mem_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [MASK_W-1:0] dcache_we,
    input  logic              dcache_re,
    input  logic [DATA_W-1:0] dcache_din,
    output logic [DATA_W-1:0] dcache_dout,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rnw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    output logic [MASK_W-1:0] mem_req_mask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    localparam int OFF_W  = off_width(WORDS);
    localparam int IDX_W  = idx_width(LINES);
    localparam int TAG_W  = tag_width(WORDS, LINES);
    localparam int IDX_LO = BYTE_OFF_W + OFF_W;
    localparam int TAG_LO = IDX_LO + IDX_W;
    localparam int RAM_AW = IDX_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dc_state_e                    state_reg, state_next;
    logic [ADDR_W-1:BYTE_OFF_W]   addr_reg;
    logic [MASK_W-1:0]            we_reg;
    logic [DATA_W-1:0]            din_reg;
    logic                         store_reg;
    logic [OFF_W-1:0]             beat_reg;
    logic [DATA_W-1:0]            resp_word_reg;
    logic [LINES-1:0]             valid_reg;

    logic [TAG_W-1:0]             tag_mem [LINES];
    logic [TAG_W-1:0]             tag_rd_reg;

    // ------------------------------------------------------------------
    // Decode and control
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  cpu_idx, req_idx;
    logic [OFF_W-1:0]  cpu_off, req_off;
    logic [TAG_W-1:0]  req_tag;
    logic              hit, load_hit, store_hit;
    logic              accept, beat_fire, last_beat;
    logic [MASK_W-1:0] ram_wr_en;
    logic [RAM_AW-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data, ram_rd_data;
    logic              unused_addr_bits;

    assign cpu_idx = dcache_addr[TAG_LO-1:IDX_LO];
    assign cpu_off = dcache_addr[IDX_LO-1:BYTE_OFF_W];
    assign req_idx = addr_reg[TAG_LO-1:IDX_LO];
    assign req_off = addr_reg[IDX_LO-1:BYTE_OFF_W];
    assign req_tag = addr_reg[TAG_MSB:TAG_LO];
    assign unused_addr_bits = ^dcache_addr[BYTE_OFF_W-1:0];

    // Tag RAM and data RAM are both read with the raw CPU address every
    // cycle, so their registered outputs line up with LOOKUP of whatever
    // request was just accepted.
    assign hit       = valid_reg[req_idx] && (tag_rd_reg == req_tag);
    assign load_hit  = (state_reg == LOOKUP) && !store_reg && hit;
    assign store_hit = (state_reg == LOOKUP) &&  store_reg && hit;

    assign stall = !((state_reg == IDLE) || load_hit || (state_reg == RESPOND));

    // A new request may be taken whenever the pipeline is not frozen,
    // including the cycle of a load hit and the RESPOND cycle.
    assign accept    = !stall && (dcache_re || (dcache_we != '0));
    assign beat_fire = (state_reg == FILL_WAIT) && mem_resp_valid;
    assign last_beat = beat_fire && (beat_reg == LAST_BEAT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (store_reg)  state_next = WRITE_REQ;
                else if (hit)   state_next = accept ? LOOKUP : IDLE;
                else            state_next = FILL_REQ;
            end
            FILL_REQ: begin
                if (mem_req_ready) state_next = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (last_beat) state_next = RESPOND;
            end
            WRITE_REQ: begin
                if (mem_req_ready) state_next = IDLE;
            end
            RESPOND: begin
                state_next = accept ? LOOKUP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control / request registers (asynchronously reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            valid_reg     <= '0;
            addr_reg      <= '0;
            we_reg        <= '0;
            din_reg       <= '0;
            store_reg     <= 1'b0;
            beat_reg      <= '0;
            resp_word_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (accept) begin
                addr_reg  <= dcache_addr[ADDR_W-1:BYTE_OFF_W];
                we_reg    <= dcache_we;
                din_reg   <= dcache_din;
                store_reg <= (dcache_we != '0);   // store wins over a concurrent load
            end

            if (state_reg == FILL_REQ) begin
                beat_reg <= '0;
            end

            if (beat_fire) begin
                beat_reg <= beat_reg + OFF_W'(1);
                // Keep the requested word aside so RESPOND never reads the
                // RAM in the same cycle the final beat is written.
                if (beat_reg == req_off) begin
                    resp_word_reg <= mem_resp_data;
                end
            end

            // Line becomes valid only once every beat is in place, so an
            // abandoned fill never leaves a partially written valid line.
            if (last_beat) begin
                valid_reg[req_idx] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag RAM (not reset; validity lives in valid_reg)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (last_beat) begin
            tag_mem[req_idx] <= req_tag;
        end
        tag_rd_reg <= tag_mem[cpu_idx];
    end

    // ------------------------------------------------------------------
    // Data RAM write port: store-hit merge or fill beat
    // ------------------------------------------------------------------
    always_comb begin
        ram_wr_en   = '0;
        ram_wr_addr = {req_idx, req_off};
        ram_wr_data = din_reg;
        if (store_hit) begin
            ram_wr_en = we_reg;
        end else if (beat_fire) begin
            ram_wr_en   = '1;
            ram_wr_addr = {req_idx, beat_reg};
            ram_wr_data = mem_resp_data;
        end
    end

    dcache_line_ram #(
        .DEPTH (LINES * WORDS),
        .AW    (RAM_AW)
    ) u_line_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_addr ({cpu_idx, cpu_off}),
        .rd_data (ram_rd_data)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        dcache_dout = '0;
        if (load_hit) begin
            dcache_dout = ram_rd_data;
        end else if (state_reg == RESPOND) begin
            dcache_dout = resp_word_reg;
        end
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_rnw   = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        mem_req_mask  = '0;
        if (state_reg == FILL_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_rnw   = 1'b1;
            mem_req_addr  = {addr_reg[ADDR_W-1:IDX_LO], {IDX_LO{1'b0}}};
        end else if (state_reg == WRITE_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {addr_reg, {BYTE_OFF_W{1'b0}}};
            mem_req_data  = din_reg;
            mem_req_mask  = we_reg;
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// -----------------------------------------------------------------------------
// tb_dcache_responder
// Directed self-checking bench for dcache_responder. Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dcache_addr;
    logic [3:0]  dcache_we;
    logic        dcache_re;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rnw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcache_responder #(.LINES(64), .WORDS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .dcache_addr    (dcache_addr),
        .dcache_we      (dcache_we),
        .dcache_re      (dcache_re),
        .dcache_din     (dcache_din),
        .dcache_dout    (dcache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rnw    (mem_req_rnw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    // Present a load for one cycle; returns at the LOOKUP falling edge.
    task automatic cpu_load(input logic [31:0] a);
        dcache_addr = a; dcache_re = 1'b1; dcache_we = 4'h0;
        @(negedge clk);
        dcache_re = 1'b0;
    endtask

    // Present a store for one cycle; returns at the LOOKUP falling edge.
    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        dcache_addr = a; dcache_din = d; dcache_we = we; dcache_re = 1'b0;
        @(negedge clk);
        dcache_we = 4'h0;
    endtask

    // Called at the FILL_REQ falling edge: handshake now, then 4 beats.
    // Returns at the RESPOND falling edge.
    task automatic serve_fill(input logic [31:0] base);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = base + 32'(i);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b0;
        dcache_addr = '0; dcache_we = '0; dcache_re = 1'b0; dcache_din = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
        n_checks++; if (dcache_dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 00000000", dcache_dout); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got %b want 0", stall); end
        $display("reset released stall=%b req_valid=%b", stall, mem_req_valid);
    endtask

    task automatic test_cold_miss;
        int extra_req = 0;
        cpu_load(32'h1000_0040);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL cold_lookup_stall: got %b want 1", stall); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL cold_lookup_req: got %b want 0", mem_req_valid); end
        @(negedge clk);
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL cold_req_valid: got %b want 1", mem_req_valid); end
        n_checks++; if (mem_req_rnw !== 1'b1) begin n_fail++; $display("FAIL cold_req_rnw: got %b want 1", mem_req_rnw); end
        n_checks++; if (mem_req_addr !== 32'h1000_0040) begin n_fail++; $display("FAIL cold_req_addr: got %h want 10000040", mem_req_addr); end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL cold_wait_req: got %b want 0", mem_req_valid); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL cold_wait_stall: got %b want 1", stall); end
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hA0 + 32'(i);
            @(negedge clk);
            if (mem_req_valid) extra_req++;
        end
        mem_resp_valid = 1'b0;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL cold_respond_stall: got %b want 0", stall); end
        n_checks++; if (dcache_dout !== 32'hA0) begin n_fail++; $display("FAIL cold_respond_dout: got %h want 000000a0", dcache_dout); end
        @(negedge clk);
        if (mem_req_valid) extra_req++;
        n_checks++; if (extra_req !== 0) begin n_fail++; $display("FAIL cold_extra_requests: got %0d want 0", extra_req); end
        $display("load  addr=10000040 miss, filled, dout=%h", 32'hA0);
    endtask

    task automatic test_load_hit;
        cpu_load(32'h1000_0044);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hit_stall: got %b want 0", stall); end
        n_checks++; if (dcache_dout !== 32'hA1) begin n_fail++; $display("FAIL hit_dout: got %h want 000000a1", dcache_dout); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL hit_req: got %b want 0", mem_req_valid); end
        $display("load  addr=10000044 hit dout=%h", dcache_dout);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        dcache_addr = 32'h1000_0048; dcache_re = 1'b1;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_first_stall: got %b want 0", stall); end
        n_checks++; if (dcache_dout !== 32'hA2) begin n_fail++; $display("FAIL b2b_first_dout: got %h want 000000a2", dcache_dout); end
        $display("load  addr=10000048 hit dout=%h", dcache_dout);
        dcache_addr = 32'h1000_004C;
        @(negedge clk);
        dcache_re = 1'b0;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_second_stall: got %b want 0", stall); end
        n_checks++; if (dcache_dout !== 32'hA3) begin n_fail++; $display("FAIL b2b_second_dout: got %h want 000000a3", dcache_dout); end
        $display("load  addr=1000004c hit dout=%h", dcache_dout);
        @(negedge clk);
    endtask

    task automatic test_store_hit;
        cpu_store(32'h1000_0044, 32'h0000_BEEF, 4'b0011);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL st_hit_lookup_stall: got %b want 1", stall); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL st_hit_lookup_req: got %b want 0", mem_req_valid); end
        @(negedge clk);
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL st_hit_req_valid: got %b want 1", mem_req_valid); end
        n_checks++; if (mem_req_rnw !== 1'b0) begin n_fail++; $display("FAIL st_hit_req_rnw: got %b want 0", mem_req_rnw); end
        n_checks++; if (mem_req_addr !== 32'h1000_0044) begin n_fail++; $display("FAIL st_hit_req_addr: got %h want 10000044", mem_req_addr); end
        n_checks++; if (mem_req_data !== 32'h0000_BEEF) begin n_fail++; $display("FAIL st_hit_req_data: got %h want 0000beef", mem_req_data); end
        n_checks++; if (mem_req_mask !== 4'b0011) begin n_fail++; $display("FAIL st_hit_req_mask: got %b want 0011", mem_req_mask); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL st_hit_handshake_stall: got %b want 1", stall); end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL st_hit_release_stall: got %b want 0", stall); end
        $display("store addr=10000044 data=0000beef we=0011 hit");
        cpu_load(32'h1000_0044);
        n_checks++; if (dcache_dout !== 32'h0000_BEEF) begin n_fail++; $display("FAIL st_hit_merged_dout: got %h want 0000beef", dcache_dout); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL st_hit_reload_stall: got %b want 0", stall); end
        $display("load  addr=10000044 hit dout=%h", dcache_dout);
        @(negedge clk);
        cpu_load(32'h1000_0040);
        n_checks++; if (dcache_dout !== 32'hA0) begin n_fail++; $display("FAIL st_hit_neighbour_dout: got %h want 000000a0", dcache_dout); end
        $display("load  addr=10000040 hit dout=%h", dcache_dout);
        @(negedge clk);
    endtask

    task automatic test_store_miss;
        int wr_cnt = 0;
        int rd_cnt = 0;
        mem_req_ready = 1'b1;
        cpu_store(32'h1000_0400, 32'h1234_5678, 4'hF);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL st_miss_lookup_stall: got %b want 1", stall); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_req_valid && !mem_req_rnw) begin
                wr_cnt++;
                n_checks++; if (mem_req_addr !== 32'h1000_0400) begin n_fail++; $display("FAIL st_miss_req_addr: got %h want 10000400", mem_req_addr); end
                n_checks++; if (mem_req_mask !== 4'hF) begin n_fail++; $display("FAIL st_miss_req_mask: got %b want 1111", mem_req_mask); end
            end
            if (mem_req_valid && mem_req_rnw) rd_cnt++;
        end
        mem_req_ready = 1'b0;
        n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL st_miss_write_count: got %0d want 1", wr_cnt); end
        n_checks++; if (rd_cnt !== 0) begin n_fail++; $display("FAIL st_miss_fill_count: got %0d want 0", rd_cnt); end
        $display("store addr=10000400 data=12345678 we=1111 miss, writes=%0d", wr_cnt);
        cpu_load(32'h1000_0400);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL st_miss_line_valid: stall got %b want 1", stall); end
        @(negedge clk);
        serve_fill(32'hB0);
        n_checks++; if (dcache_dout !== 32'hB0) begin n_fail++; $display("FAIL st_miss_refill_dout: got %h want 000000b0", dcache_dout); end
        $display("load  addr=10000400 miss, filled, dout=%h", dcache_dout);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill;
        cpu_load(32'h2000_0080);
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hD0 + 32'(i);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b want 0", stall); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_req_valid: got %b want 0", mem_req_valid); end
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midrst_hold_stall: got %b want 0", stall); end
        n_checks++; if (dcache_dout !== 32'h0) begin n_fail++; $display("FAIL midrst_dout: got %h want 00000000", dcache_dout); end
        rst = 1'b1;
        @(negedge clk);
        $display("reset during fill of 20000080 after 2 beats");
        cpu_load(32'h2000_0080);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL midrst_remiss: stall got %b want 1", stall); end
        @(negedge clk);
        serve_fill(32'hC0);
        n_checks++; if (dcache_dout !== 32'hC0) begin n_fail++; $display("FAIL midrst_refill_dout: got %h want 000000c0", dcache_dout); end
        $display("load  addr=20000080 miss, filled, dout=%h", dcache_dout);
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        // Reset above cleared every valid bit, so this line misses again.
        cpu_load(32'h1000_0044);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL bp_lookup_stall: got %b want 1", stall); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cycle %0d: got %b want 1", i, mem_req_valid); end
            n_checks++; if (mem_req_addr !== 32'h1000_0040) begin n_fail++; $display("FAIL bp_addr cycle %0d: got %h want 10000040", i, mem_req_addr); end
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL bp_stall cycle %0d: got %b want 1", i, stall); end
            @(negedge clk);
        end
        serve_fill(32'hE0);
        n_checks++; if (dcache_dout !== 32'hE1) begin n_fail++; $display("FAIL bp_respond_dout: got %h want 000000e1", dcache_dout); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL bp_respond_stall: got %b want 0", stall); end
        $display("load  addr=10000044 miss after 5 backpressure cycles, dout=%h", dcache_dout);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_load_hit();
        test_back_to_back();
        test_store_hit();
        test_store_miss();
        test_reset_mid_fill();
        test_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
